// File: rtl/sprite_pkg.sv
// sprite_pkg: shared word layout, velocity type and walk FSM states for the sprite motion updater.
//   XPOS_LSB / YPOS_LSB : bit positions of xpos and ypos inside a sprite position word
//   ATTR_WORD_OFS       : offset of the attribute word from the position word (never written)
//   vel_t               : 3-bit signed per-axis velocity (-3..+3)
//   state_t             : walk FSM states
package sprite_pkg;
    localparam int XPOS_LSB      = 0;
    localparam int YPOS_LSB      = 8;
    localparam int ATTR_WORD_OFS = 1;

    typedef logic signed [2:0] vel_t;

    typedef enum logic [2:0] {IDLE, RD, WAIT, CAP, CALC, WR, NEXT} state_t;
endpackage

// File: rtl/sprite_motion_updater_if.sv
// sprite_motion_updater_if: sprite table RAM port shared between the motion updater and the RAM/arbiter.
//   ram_addr  : word address (position word of sprite i is 2*i)
//   ram_wdata : write data
//   ram_we    : write strobe
//   ram_rdata : synchronous RAM read data, valid one clock after the address
//   ram_busy  : renderer currently owns the RAM
//   master : updater side, slave : RAM side
interface sprite_motion_updater_if #(
    parameter int NB = 5
);
    logic [NB:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic        ram_busy;

    modport master (output ram_addr, ram_wdata, ram_we, input ram_rdata, ram_busy);
    modport slave  (input ram_addr, ram_wdata, ram_we, output ram_rdata, ram_busy);
endinterface

// File: rtl/sprite_axis_step.sv
// sprite_axis_step: one-axis position update; bounces at 0/max by default, wraps when SPRITE_WRAP_EN is defined.
//   pos     : current position (0..max)
//   vel     : signed velocity
//   max     : largest legal position
//   new_pos : updated position
//   new_vel : updated velocity (negated on a bounce, unchanged when wrapping)
module sprite_axis_step
    import sprite_pkg::*;
(
    input  logic [7:0] pos,
    input  vel_t       vel,
    input  logic [7:0] max,
    output logic [7:0] new_pos,
    output vel_t       new_vel
);
    logic signed [9:0] n;
    logic signed [9:0] lim;

    assign n   = $signed({2'b00, pos}) + $signed({{7{vel[2]}}, vel});
    assign lim = $signed({2'b00, max});

`ifdef SPRITE_WRAP_EN
    logic signed [9:0] wrapped;

    assign wrapped = n < 0 ? n + lim + 10'sd1 : n > lim ? n - lim - 10'sd1 : n;
    assign new_pos = wrapped[7:0];
    assign new_vel = vel;
`else
    assign new_pos = n < 0 ? 8'd0 : n > lim ? max : n[7:0];
    assign new_vel = (n < 0 || n > lim) ? -vel : vel;
`endif
endmodule

// File: rtl/sprite_motion_updater.sv
// sprite_motion_updater: once per frame reads every sprite position word, steps it by its velocity and writes it back.
//   clk, reset  : clock, synchronous active-high reset
//   hpos, vpos  : raster counters; walk starts at vpos==START_LINE, hpos==0
//   enable      : sampled at the start point, 0 skips the frame
//   ram         : sprite table RAM port (master side)
//   frame_done  : one-cycle pulse after the last sprite has been written
// Optional macro SPRITE_WRAP_EN (in sprite_axis_step): edges wrap instead of bounce.
module sprite_motion_updater
    import sprite_pkg::*;
#(
    parameter int NB         = 5,
    parameter int START_LINE = 256,
    parameter int XMAX       = 240,
    parameter int YMAX       = 224
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [8:0]               hpos,
    input  logic [8:0]               vpos,
    input  logic                     enable,
    sprite_motion_updater_if.master  ram,
    output logic                     frame_done
);
    localparam int N = 1 << NB;

    state_t        state, state_nx;
    logic [NB-1:0] idx;
    logic [7:0]    x, y, nx, ny;
    vel_t          vx [N];
    vel_t          vy [N];
    vel_t          nvx, nvy;
    logic [NB:0]   addr_q;
    logic [15:0]   wdata_q;
    logic          we_q;
    logic          start, last;
    logic          go, ld_addr, cap, calc, wr, nxt;

    assign start = enable && vpos == 9'(START_LINE) && hpos == 9'd0;
    assign last  = &idx;

    assign ram.ram_addr  = addr_q;
    assign ram.ram_wdata = wdata_q;
    // A pending write is held off while the renderer owns the RAM.
    assign ram.ram_we    = we_q && !ram.ram_busy;

    sprite_axis_step u_x (.pos(x), .vel(vx[idx]), .max(8'(XMAX)), .new_pos(nx), .new_vel(nvx));
    sprite_axis_step u_y (.pos(y), .vel(vy[idx]), .max(8'(YMAX)), .new_pos(ny), .new_vel(nvy));

    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE) begin
            state_nx = start ? RD : IDLE;
        end else if (ram.ram_busy) begin
            // Data read before or during a busy window may be stale: re-read the sprite.
            state_nx = (state == WAIT || state == CAP) ? RD : state;
        end else begin
            case (state)
                RD:      state_nx = WAIT;
                WAIT:    state_nx = CAP;
                CAP:     state_nx = CALC;
                CALC:    state_nx = WR;
                WR:      state_nx = NEXT;
                NEXT:    state_nx = last ? IDLE : RD;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        go      = state != IDLE && !ram.ram_busy;
        ld_addr = go && state == RD;
        cap     = go && state == CAP;
        calc    = go && state == CALC;
        wr      = go && state == WR;
        nxt     = go && state == NEXT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            x          <= '0;
            y          <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            frame_done <= 1'b0;
            for (int k = 0; k < N; k++) begin
                vx[k] <= k[0] ? -3'sd1 : 3'sd1;
                vy[k] <= k[1] ? -3'sd1 : 3'sd1;
            end
        end else begin
            frame_done <= nxt && last;
            we_q       <= wr || (we_q && ram.ram_busy);
            if (ld_addr) addr_q <= {idx, 1'b0} & ~(NB+1)'(ATTR_WORD_OFS);
            if (cap) begin
                x <= ram.ram_rdata[XPOS_LSB +: 8];
                y <= ram.ram_rdata[YPOS_LSB +: 8];
            end
            if (calc) begin
                x       <= nx;
                y       <= ny;
                vx[idx] <= nvx;
                vy[idx] <= nvy;
            end
            if (wr) begin
                wdata_q[XPOS_LSB +: 8] <= x;
                wdata_q[YPOS_LSB +: 8] <= y;
            end
            if (nxt) idx <= last ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_sprite_motion_updater.sv
// tb_sprite_motion_updater: self-checking bench with a sprite RAM model and a per-sprite motion reference model.
module tb_sprite_motion_updater;
    import sprite_pkg::*;

    localparam int NB = 5;
    localparam int N = 1 << NB;
    localparam int START_LINE = 256;
    localparam int XMAX = 240;
    localparam int YMAX = 224;

    typedef struct {
        int          idx;
        logic [15:0] init;
        logic [15:0] exp1;
        logic [15:0] exp2;
    } vec_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        enable = 1;
    logic        frame_done;
    logic [8:0]  hpos = '0;
    logic [8:0]  vpos = '0;
    logic        tb_we = 0;
    logic [NB:0] tb_addr = '0;
    logic [15:0] tb_wdata = '0;

    logic [15:0] mem [2*N];
    logic [15:0] attr [N];
    int mx [N];
    int my [N];
    int mvx [N];
    int mvy [N];
    vec_t vt [8];

    int checks = 0;
    int passes = 0;
    int wr_cnt = 0;
    int odd_wr = 0;
    int busy_wr = 0;
    int done_cnt = 0;

    sprite_motion_updater_if #(.NB(NB)) bus();

    sprite_motion_updater #(
        .NB(NB), .START_LINE(START_LINE), .XMAX(XMAX), .YMAX(YMAX)
    ) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .enable(enable),
        .ram(bus), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Sync RAM; while the renderer owns it the read port returns unrelated data.
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_wdata;
        else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            wr_cnt <= wr_cnt + 1;
            if (bus.ram_addr[0]) odd_wr <= odd_wr + 1;
        end
        if (bus.ram_we && bus.ram_busy) busy_wr <= busy_wr + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
        bus.ram_rdata <= bus.ram_busy ? 16'($urandom) : mem[bus.ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic void step(input int p, input int v, input int m, output int np, output int nv);
        int n = p + v;
        nv = v;
`ifdef SPRITE_WRAP_EN
        np = n < 0 ? n + m + 1 : n > m ? n - m - 1 : n;
`else
        if (n < 0 || n > m) nv = -v;
        np = n < 0 ? 0 : n > m ? m : n;
`endif
    endfunction

    task automatic model_sprite(input int i);
        step(mx[i], mvx[i], XMAX, mx[i], mvx[i]);
        step(my[i], mvy[i], YMAX, my[i], mvy[i]);
    endtask

    task automatic model_reset_vel();
        for (int i = 0; i < N; i++) begin
            mvx[i] = (i % 2) ? -1 : 1;
            mvy[i] = ((i / 2) % 2) ? -1 : 1;
        end
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s pos%0d", tag, i), mem[2*i], {8'(my[i]), 8'(mx[i])});
            if (mem[2*i+1] !== attr[i]) bad++;
        end
        chk($sformatf("%s attr words", tag), bad, 0);
    endtask

    task automatic wr_mem(input int a, input logic [15:0] d);
        tb_addr = (NB+1)'(a);
        tb_wdata = d;
        tb_we = 1;
        cyc();
        tb_we = 0;
    endtask

    task automatic pulse_start();
        vpos = 9'(START_LINE);
        hpos = '0;
        cyc();
        vpos = '0;
    endtask

    // mode 0: plain, 1: busy for 10 cycles from sprite 5 CAP, 2: random busy and re-trigger attempts
    task automatic run_frame(input int mode, input string tag, output int lat);
        int d0 = done_cnt;
        lat = -1;
        pulse_start();
        for (int c = 1; c <= 6*N + 400; c++) begin
            cyc();
            if (frame_done) begin
                lat = c;
                break;
            end
            if (mode == 1) bus.ram_busy = (c >= 32 && c < 42);
            if (mode == 2) begin
                bus.ram_busy = ($urandom_range(0, 3) == 0);
                vpos = ($urandom_range(0, 15) == 0) ? 9'(START_LINE) : 9'd0;
            end
        end
        bus.ram_busy = 0;
        vpos = '0;
        chk($sformatf("%s done seen", tag), lat > 0, 1);
        cyc();
        chk($sformatf("%s done one cycle", tag), frame_done, 0);
        cyc();
        chk($sformatf("%s done count", tag), done_cnt - d0, 1);
    endtask

    initial begin
        int lat, w0, d0;
        vt[0] = '{0, 16'h1020, 16'h1121, 16'h1222};
        vt[1] = '{6, 16'hE000, 16'hDF01, 16'hDE02};
        vt[2] = '{9, 16'h00F0, 16'h01EF, 16'h02EE};
        vt[3] = '{31, 16'h8080, 16'h7F7F, 16'h7E7E};
`ifdef SPRITE_WRAP_EN
        vt[4] = '{1, 16'h1000, 16'h11F0, 16'h12EF};
        vt[5] = '{2, 16'h30F0, 16'h2F00, 16'h2E01};
        vt[6] = '{3, 16'h0000, 16'hE0F0, 16'hDFEF};
        vt[7] = '{4, 16'hE050, 16'h0051, 16'h0152};
`else
        vt[4] = '{1, 16'h1000, 16'h1100, 16'h1201};
        vt[5] = '{2, 16'h30F0, 16'h2FF0, 16'h2EEF};
        vt[6] = '{3, 16'h0000, 16'h0000, 16'h0101};
        vt[7] = '{4, 16'hE050, 16'hE051, 16'hDF52};
`endif
        bus.ram_busy = 0;
        repeat (3) cyc();
        chk("reset ram_we", bus.ram_we, 0);
        chk("reset ram_addr", 32'(bus.ram_addr), 0);
        chk("reset ram_wdata", bus.ram_wdata, 0);
        chk("reset frame_done", frame_done, 0);
        reset = 0;
        cyc();

        model_reset_vel();
        for (int i = 0; i < N; i++) begin
            mx[i] = $urandom_range(0, XMAX);
            my[i] = $urandom_range(0, YMAX);
            attr[i] = 16'($urandom);
        end
        foreach (vt[k]) begin
            mx[vt[k].idx] = int'(vt[k].init[7:0]);
            my[vt[k].idx] = int'(vt[k].init[15:8]);
        end
        for (int i = 0; i < N; i++) begin
            wr_mem(2*i, {8'(my[i]), 8'(mx[i])});
            wr_mem(2*i+1, attr[i]);
        end

        run_frame(0, "f1", lat);
        chk("f1 latency", lat, 6*N);
        for (int i = 0; i < N; i++) model_sprite(i);
        check_mem("f1");
        foreach (vt[k]) chk($sformatf("vec f1 sprite%0d", vt[k].idx), mem[2*vt[k].idx], vt[k].exp1);

        run_frame(0, "f2", lat);
        chk("f2 latency", lat, 6*N);
        for (int i = 0; i < N; i++) model_sprite(i);
        check_mem("f2");
        foreach (vt[k]) chk($sformatf("vec f2 sprite%0d", vt[k].idx), mem[2*vt[k].idx], vt[k].exp2);

        w0 = wr_cnt;
        run_frame(1, "busy5", lat);
        chk("busy5 no write while busy", busy_wr, 0);
        chk("busy5 write count", wr_cnt - w0, N);
        for (int i = 0; i < N; i++) model_sprite(i);
        check_mem("busy5");

        for (int f = 0; f < 3; f++) begin
            w0 = wr_cnt;
            run_frame(2, $sformatf("rand%0d", f), lat);
            chk($sformatf("rand%0d write count", f), wr_cnt - w0, N);
            for (int i = 0; i < N; i++) model_sprite(i);
            check_mem($sformatf("rand%0d", f));
        end
        chk("no write while busy", busy_wr, 0);

        enable = 0;
        w0 = wr_cnt;
        d0 = done_cnt;
        pulse_start();
        repeat (6*N + 20) cyc();
        chk("disabled writes", wr_cnt - w0, 0);
        chk("disabled done", done_cnt - d0, 0);
        check_mem("disabled");
        enable = 1;

        w0 = wr_cnt;
        d0 = done_cnt;
        pulse_start();
        repeat (46) cyc();
        reset = 1;
        cyc();
        chk("abort ram_we", bus.ram_we, 0);
        chk("abort frame_done", frame_done, 0);
        reset = 0;
        repeat (3) cyc();
        chk("abort writes", wr_cnt - w0, 7);
        chk("abort done", done_cnt - d0, 0);
        for (int i = 0; i < 7; i++) model_sprite(i);
        model_reset_vel();
        check_mem("abort");

        run_frame(0, "restart", lat);
        chk("restart latency", lat, 6*N);
        for (int i = 0; i < N; i++) model_sprite(i);
        check_mem("restart");

        chk("attr never written", odd_wr, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
